// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline front/back ends, the arbiter and the unified memory.
//   slave  : arbiter side (takes fetch/data requests and mem_rdata, drives responses,
//            memory strobes and pipeline controls)
//   master : environment side (IF/MEM stages and the memory model)
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // Fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  // Data port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [3:0]        d_be;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  // Memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_rdata;
  // Pipeline controls
  logic              PCWrite;
  logic              if_id_write;
  logic              mem_stall;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    output if_rdata, if_valid, d_rdata, d_valid,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    output PCWrite, if_id_write, mem_stall
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    input  if_rdata, if_valid, d_rdata, d_valid,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    input  PCWrite, if_id_write, mem_stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port fixed-latency memory between instruction fetch and
// data loads/stores. One access is in flight at a time; responses are registered and
// signalled by a one-cycle valid pulse. Data wins over fetch, except that fetch is
// forced through after STARVE_LIMIT consecutive data grants taken while it waited.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : request/response, memory and pipeline-control signals (slave side)
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned LatW    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned StreakW = $clog2(STARVE_LIMIT + 1);
  localparam logic [LatW-1:0]    LatInit   = LatW'(MEM_LATENCY - 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StIfBusy, StDBusy} state_e;

  state_e              state_q;
  logic [LatW-1:0]     lat_cnt_q;
  logic [StreakW-1:0]  d_streak_q;
  logic                is_store_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                if_valid_q;
  logic                d_valid_q;

  logic                fetch_starved;
  logic                grant_d;
  logic                grant_i;
  logic [ADDR_W-1:0]   addr_sel;

  // Grants are only possible in IDLE and are masked while reset is asserted so that
  // every output reads 0 during reset.
  always_comb begin
    fetch_starved = bus.if_req && (d_streak_q == StreakMax);
    grant_d       = reset && (state_q == StIdle) && bus.d_req && !fetch_starved;
    grant_i       = reset && (state_q == StIdle) && bus.if_req && !grant_d;
  end

  // Memory strobes for the issue cycle, steered from the granted requester.
  always_comb begin
    addr_sel      = '0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    if (grant_d) begin
      addr_sel      = bus.d_addr;
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.d_we;
      bus.mem_wdata = bus.d_wdata;
      bus.mem_be    = bus.d_be;
    end else if (grant_i) begin
      addr_sel      = bus.if_addr;
      bus.mem_en    = 1'b1;
    end
    bus.mem_addr = addr_sel;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      lat_cnt_q  <= '0;
      d_streak_q <= '0;
      is_store_q <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_d) begin
            state_q    <= StDBusy;
            lat_cnt_q  <= LatInit;
            is_store_q <= bus.d_we;
            // A data grant with fetch waiting implies the streak is below the limit.
            d_streak_q <= bus.if_req ? d_streak_q + 1'b1 : '0;
          end else if (grant_i) begin
            state_q    <= StIfBusy;
            lat_cnt_q  <= LatInit;
            d_streak_q <= '0;
          end
        end
        StIfBusy: begin
          if (lat_cnt_q == '0) begin
            if_rdata_q <= bus.mem_rdata;
            if_valid_q <= 1'b1;
            state_q    <= StIdle;
          end else begin
            lat_cnt_q <= lat_cnt_q - 1'b1;
          end
        end
        StDBusy: begin
          if (lat_cnt_q == '0) begin
            if (!is_store_q) begin
              d_rdata_q <= bus.mem_rdata;
            end
            d_valid_q <= 1'b1;
            state_q   <= StIdle;
          end else begin
            lat_cnt_q <= lat_cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.if_rdata    = if_rdata_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.d_valid     = d_valid_q;
  assign bus.mem_stall   = reset && bus.d_req && !d_valid_q;
  assign bus.PCWrite     = if_valid_q && !bus.mem_stall;
  assign bus.if_id_write = bus.PCWrite;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares a single-port unified instruction/data memory between the IF stage (fetch) and the MEM stage (loads/stores) of the 5-stage pipeline.
- Issues one access at a time to a fixed-latency memory, tracks the outstanding access, and returns registered responses.
- Generates the PCWrite / if_id_write fetch-advance controls and the mem_stall backpressure.
- Data requests have priority over fetches; a bounded starvation guard protects fetch.

Parameters:
MEM_LATENCY, 2, cycles from the issue cycle to mem_rdata valid (>=1)
STARVE_LIMIT, 4, max consecutive data grants while a fetch is pending (>=1)
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
if_req  input  1  fetch request (level, held until if_valid)
if_addr  input  ADDR_W  fetch address (PC), stable while if_req
if_rdata  output  DATA_W  fetched instruction, registered
if_valid  output  1  one-cycle fetch-complete pulse
d_req  input  1  data request (level, held until d_valid)
d_we  input  1  1=store, 0=load
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_be  input  4  store byte enables
d_rdata  output  DATA_W  load data, registered
d_valid  output  1  one-cycle data-complete pulse (loads and stores)
mem_en  output  1  memory access strobe, one cycle per access
mem_we  output  1  memory write enable (qualified by mem_en)
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_be  output  4  memory byte enables
mem_rdata  input  DATA_W  memory read data, valid MEM_LATENCY cycles after issue
PCWrite  output  1  PC may advance
if_id_write  output  1  IF/ID register may load
mem_stall  output  1  freeze pipeline at MEM stage

Behaviour:
- FSM states: IDLE, IF_BUSY, D_BUSY. Down-counter lat_cnt, streak counter d_streak (0..STARVE_LIMIT).
- Reset (reset=0, async): state=IDLE, lat_cnt=0, d_streak=0, if_rdata=0, d_rdata=0. All outputs 0 during reset, and mem_* address/data are 0.
- IDLE grant:
  - d_req && !(if_req && d_streak==STARVE_LIMIT) -> issue data.
  - Else if_req -> issue fetch.
  - Else nothing.
- Issue cycle T:
  - mem_en=1. mem_addr, mem_we, mem_wdata and mem_be are driven combinationally from the granted requester; mem_we=0 for fetch.
  - Next state is the matching BUSY state, with lat_cnt=MEM_LATENCY-1.
  - mem_en is 0 in every non-issue cycle.
- BUSY: lat_cnt decrements each cycle. In cycle T+MEM_LATENCY (lat_cnt==0), mem_rdata is registered into the granted requester's rdata (loads and fetches only; d_rdata is unchanged on stores), and the state returns to IDLE.
- Response: x_valid=1 for exactly cycle T+MEM_LATENCY+1. In that same cycle the FSM is in IDLE and may issue the next access, so throughput is one access per MEM_LATENCY+1 cycles.
- d_streak:
  - Increments on each data issue while if_req=1, saturating at STARVE_LIMIT.
  - Clears on a fetch issue, or on a data issue while if_req=0.
- Simultaneous requests with d_streak<STARVE_LIMIT -> data wins. At the limit -> fetch wins once, then d_streak=0.
- Fetch control: PCWrite = if_valid && !mem_stall; if_id_write = PCWrite.
- mem_stall = d_req && !d_valid (combinational).
- Request dropped before issue: no access. Dropped after issue: the access completes and the valid pulse still fires (the requester ignores it).
- Addresses are passed unmodified; there is no alignment checking.
- Reset asserted mid-access: the access is abandoned, no valid pulse fires, and the FSM is in IDLE on release.

Test Plan:
- Fetch only, MEM_LATENCY=2: if_req=1, if_addr=0x00000010 in cycle 0 -> mem_en=1, mem_addr=0x10 in cycle 0; mem_rdata=0x00500093 in cycle 2; if_valid=1 and if_rdata=0x00500093 in cycle 3; PCWrite=1 in cycle 3.
- Simultaneous: if_req=1, d_req=1 load from 0x100 in cycle 0 -> data issued in cycle 0 and d_valid in cycle 3, mem_stall=1 in cycles 0-2; fetch issued in cycle 3, if_valid in cycle 6.
- Store: d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, d_be=4'b0011 -> mem_we=1 with those values at issue; d_valid pulses, d_rdata unchanged.
- Starvation, STARVE_LIMIT=4: d_req and if_req held high continuously -> grant sequence D,D,D,D,I,D,D,D,D,I; a fetch issues every 5th grant.
- Reset mid-access: reset=0 one cycle after a data issue -> all outputs 0 immediately, no d_valid afterwards; the first request after release is granted in its first cycle.
- Back-to-back fetches: if_req held across addresses 0x0 and 0x4 -> second mem_en in the same cycle as the first if_valid (3-cycle spacing).
